sd_residual_acc: RTL and testbench

Downstream stage of the signed-digit vector multiplier (SDVM). Consumes one SDVM partial product per cycle, given as a redundant plus/minus vector pair. Accumulates each partial product into a shifted residual and emits one radix-2 signed result digit per accepted product. The result digits use the same 2-bit digit encoding that SDVM takes as digit_select, so this stage can drive a further SDVM directly.

---
 rtl/sd_pkg.sv | 21 ++
 rtl/sd_digit_sel.sv | 35 +++
 rtl/sd_residual_acc.sv | 134 +++++++++++++
 tb/tb_sd_residual_acc.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared definitions for the signed-digit datapath (SDVM and its online stages).
//   SD_POS / SD_NEG / SD_ZERO : 2-bit signed-digit encodings (+1 / -1 / 0)
//   sd_res_width()            : residual register width for a given vector width
//   sd_state_e                : IDLE / RUN control state
package sd_pkg;

  localparam logic [1:0] SD_POS  = 2'b10;
  localparam logic [1:0] SD_NEG  = 2'b01;
  localparam logic [1:0] SD_ZERO = 2'b00;

  // Residual spans -S..S with S = 2^num_bits, so it needs a sign bit plus one.
  function automatic int unsigned sd_res_width(input int unsigned num_bits);
    return num_bits + 2;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sd_state_e;

endpackage

// File: rtl/sd_digit_sel.sv
// Radix-2 signed-digit selection for online stages (purely combinational).
// Ports:
//   v      : in,  signed Num_bits+3 bits, candidate residual 2*w + p
//   digit  : out, encoded digit (SD_POS / SD_NEG / SD_ZERO)
//   w_next : out, signed Num_bits+2 bits, v - digit*2S
module sd_digit_sel
  import sd_pkg::*;
#(
  parameter int unsigned Num_bits = 4
) (
  input  logic signed [Num_bits+2:0] v,
  output logic        [1:0]          digit,
  output logic signed [Num_bits+1:0] w_next
);

  localparam int unsigned VW = Num_bits + 3;
  localparam int unsigned WW = sd_res_width(Num_bits);

  localparam logic signed [VW-1:0] S_V     = VW'(1 << Num_bits);
  localparam logic signed [VW-1:0] TWO_S_V = VW'(2 << Num_bits);

  // Thresholds keep the returned residual inside -S..S for any |p| < S.
  always_comb begin
    digit  = SD_ZERO;
    w_next = WW'(v);
    if (v >= S_V) begin
      digit  = SD_POS;
      w_next = WW'(v - TWO_S_V);
    end else if (v < -S_V) begin
      digit  = SD_NEG;
      w_next = WW'(v + TWO_S_V);
    end
  end

endmodule

// File: rtl/sd_residual_acc.sv
// Residual accumulator behind the SDVM: folds one redundant partial product
// per accept into a shifted residual and emits one radix-2 signed digit.
// Optional build macro: SD_RESIDUAL_DBG_EN (adds residual_out + range check).
// Ports:
//   clk, asyn_reset      : clock, synchronous active-high reset
//   enable               : clock enable, 0 freezes state
//   start                : begin an operation (ignored while busy)
//   pp_valid/plus/minus  : partial product from SDVM (redundant pair)
//   busy                 : operation in progress
//   z_digit, z_valid     : result digit and its single-cycle valid
//   done                 : pulses with the last digit of an operation
//   residual_out         : (debug build only) current residual w
module sd_residual_acc
  import sd_pkg::*;
#(
  parameter int unsigned Num_bits   = 4,
  parameter int unsigned Num_digits = 8
) (
  input  logic                clk,
  input  logic                asyn_reset,
  input  logic                enable,
  input  logic                start,
  input  logic                pp_valid,
  input  logic [Num_bits-1:0] pp_plus,
  input  logic [Num_bits-1:0] pp_minus,
  output logic                busy,
  output logic [1:0]          z_digit,
  output logic                z_valid,
  output logic                done
`ifdef SD_RESIDUAL_DBG_EN
  ,
  output logic signed [Num_bits+1:0] residual_out
`endif
);

  localparam int unsigned WW = sd_res_width(Num_bits);
  localparam int unsigned VW = Num_bits + 3;
  localparam int unsigned CW = $clog2(Num_digits + 1);

  sd_state_e             state_q, state_d;
  logic signed [WW-1:0]  w_q, w_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [1:0]            z_digit_q, z_digit_d;
  logic                  z_valid_q, z_valid_d;
  logic                  done_q, done_d;

  logic signed [VW-1:0]  p_c, v_c;
  logic [1:0]            sel_digit_c;
  logic signed [WW-1:0]  sel_w_c;

  // Zero-extended difference; modular subtraction yields the signed value.
  assign p_c = VW'({1'b0, pp_plus}) - VW'({1'b0, pp_minus});
  assign v_c = {w_q, 1'b0} + p_c;

  sd_digit_sel #(
    .Num_bits (Num_bits)
  ) u_digit_sel (
    .v      (v_c),
    .digit  (sel_digit_c),
    .w_next (sel_w_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (asyn_reset) begin
      state_q   <= IDLE;
      w_q       <= '0;
      cnt_q     <= '0;
      z_digit_q <= SD_ZERO;
      z_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      cnt_q     <= cnt_d;
      z_digit_q <= z_digit_d;
      z_valid_q <= z_valid_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic; pulses default low, everything else holds.
  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    cnt_d     = cnt_q;
    z_digit_d = z_digit_q;
    z_valid_d = 1'b0;
    done_d    = 1'b0;
    if (enable) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = RUN;
            w_d     = '0;
            cnt_d   = CW'(Num_digits);
          end
        end
        RUN: begin
          if (pp_valid) begin
            w_d       = sel_w_c;
            z_digit_d = sel_digit_c;
            z_valid_d = 1'b1;
            cnt_d     = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy    = (state_q == RUN);
  assign z_digit = z_digit_q;
  assign z_valid = z_valid_q;
  assign done    = done_q;

`ifdef SD_RESIDUAL_DBG_EN
  localparam logic signed [WW-1:0] S_W = WW'(1 << Num_bits);

  assign residual_out = w_q;

  always_ff @(posedge clk) begin
    if (!asyn_reset) begin
      assert ((w_q >= -S_W) && (w_q <= S_W))
        else $error("residual out of range: %0d", w_q);
    end
  end
`endif

endmodule

// File: tb/tb_sd_residual_acc.sv
// Directed bench for sd_residual_acc (Num_bits=4, Num_digits=4).
module tb_sd_residual_acc;

  localparam int unsigned NB = 4;
  localparam int unsigned ND = 4;

  logic          clk = 1'b0;
  logic          asyn_reset;
  logic          enable;
  logic          start;
  logic          pp_valid;
  logic [NB-1:0] pp_plus;
  logic [NB-1:0] pp_minus;
  logic          busy;
  logic [1:0]    z_digit;
  logic          z_valid;
  logic          done;
`ifdef SD_RESIDUAL_DBG_EN
  logic signed [NB+1:0] residual_out;
`endif

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  sd_residual_acc #(
    .Num_bits   (NB),
    .Num_digits (ND)
  ) dut (
    .clk        (clk),
    .asyn_reset (asyn_reset),
    .enable     (enable),
    .start      (start),
    .pp_valid   (pp_valid),
    .pp_plus    (pp_plus),
    .pp_minus   (pp_minus),
    .busy       (busy),
    .z_digit    (z_digit),
    .z_valid    (z_valid),
    .done       (done)
`ifdef SD_RESIDUAL_DBG_EN
    ,
    .residual_out (residual_out)
`endif
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_res(input string tag, input int exp_w);
`ifdef SD_RESIDUAL_DBG_EN
    chk(tag, {2'b00, residual_out}, {2'b00, 6'(exp_w)});
`else
    if (tag.len() == 0 && exp_w == 0) $display("note: empty residual tag");
`endif
  endtask

  task automatic start_op(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, ".busy"},   8'(busy),    8'd1);
    chk({tag, ".zvalid"}, 8'(z_valid), 8'd0);
  endtask

  task automatic accept(input string tag, input logic [NB-1:0] pl, input logic [NB-1:0] mi,
                        input logic [1:0] exp_d, input logic last, input int exp_w);
    pp_plus  = pl;
    pp_minus = mi;
    pp_valid = 1'b1;
    step();
    pp_valid = 1'b0;
    chk({tag, ".zvalid"}, 8'(z_valid), 8'd1);
    chk({tag, ".digit"},  8'(z_digit), 8'(exp_d));
    chk({tag, ".done"},   8'(done),    8'(last));
    chk({tag, ".busy"},   8'(busy),    8'(!last));
    chk_res({tag, ".w"}, exp_w);
  endtask

  // Idle or frozen cycles while busy: no digit, busy held, digit register held.
  task automatic quiet(input string tag, input int n, input logic [1:0] held_d);
    for (int i = 0; i < n; i++) begin
      step();
      chk({tag, ".zvalid"}, 8'(z_valid), 8'd0);
      chk({tag, ".done"},   8'(done),    8'd0);
      chk({tag, ".busy"},   8'(busy),    8'd1);
      chk({tag, ".digit"},  8'(z_digit), 8'(held_d));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    asyn_reset = 1'b1;
    enable     = 1'b1;
    start      = 1'b0;
    pp_valid   = 1'b0;
    pp_plus    = '0;
    pp_minus   = '0;

    // 1: reset
    step();
    step();
    asyn_reset = 1'b0;
    chk("rst.busy",   8'(busy),    8'd0);
    chk("rst.zvalid", 8'(z_valid), 8'd0);
    chk("rst.done",   8'(done),    8'd0);
    chk("rst.digit",  8'(z_digit), 8'd0);
    chk_res("rst.w", 0);

    // pp while idle is ignored
    pp_valid = 1'b1;
    pp_plus  = 4'hF;
    step();
    pp_valid = 1'b0;
    chk("idlepp.zvalid", 8'(z_valid), 8'd0);
    chk("idlepp.busy",   8'(busy),    8'd0);

    // 2: p=+15 x4
    start_op("t2.start");
    accept("t2.d0", 4'hF, 4'h0, 2'b00, 1'b0, 15);
    accept("t2.d1", 4'hF, 4'h0, 2'b10, 1'b0, 13);
    accept("t2.d2", 4'hF, 4'h0, 2'b10, 1'b0, 9);
    accept("t2.d3", 4'hF, 4'h0, 2'b10, 1'b1, 1);

    // 3: back-to-back, p=-15 x4
    start_op("t3.start");
    accept("t3.d0", 4'h0, 4'hF, 2'b00, 1'b0, -15);
    accept("t3.d1", 4'h0, 4'hF, 2'b01, 1'b0, -13);
    accept("t3.d2", 4'h0, 4'hF, 2'b01, 1'b0, -9);
    accept("t3.d3", 4'h0, 4'hF, 2'b01, 1'b1, -1);
    step();
    chk("t3.after.done", 8'(done), 8'd0);

    // 4: boundary v=16 -> +1, v=-32 -> -1; p=+8 given as plus=1100 minus=0100
    start_op("t4.start");
    accept("t4.d0", 4'hC, 4'h4, 2'b00, 1'b0, 8);
    accept("t4.d1", 4'h5, 4'h5, 2'b10, 1'b0, -16);
    accept("t4.d2", 4'hF, 4'hF, 2'b01, 1'b0, 0);
    accept("t4.d3", 4'h0, 4'h0, 2'b00, 1'b1, 0);

    // 5: stalls via pp_valid and enable
    start_op("t5.start");
    accept("t5.d0", 4'hF, 4'h0, 2'b00, 1'b0, 15);
    quiet("t5.gap0", 2, 2'b00);
    accept("t5.d1", 4'hF, 4'h0, 2'b10, 1'b0, 13);
    enable   = 1'b0;
    pp_valid = 1'b1;
    quiet("t5.en0", 3, 2'b10);
    enable   = 1'b1;
    accept("t5.d2", 4'hF, 4'h0, 2'b10, 1'b0, 9);
    quiet("t5.gap1", 2, 2'b10);
    accept("t5.d3", 4'hF, 4'h0, 2'b10, 1'b1, 1);

    // 6a: start mid-operation is ignored (w and counter keep going)
    start_op("t6a.start");
    accept("t6a.d0", 4'hF, 4'h0, 2'b00, 1'b0, 15);
    accept("t6a.d1", 4'hF, 4'h0, 2'b10, 1'b0, 13);
    start = 1'b1;
    quiet("t6a.restart", 1, 2'b10);
    start = 1'b0;
    accept("t6a.d2", 4'hF, 4'h0, 2'b10, 1'b0, 9);
    accept("t6a.d3", 4'hF, 4'h0, 2'b10, 1'b1, 1);

    // 6b: reset after two digits drops the operation
    start_op("t6b.start");
    accept("t6b.d0", 4'hF, 4'h0, 2'b00, 1'b0, 15);
    accept("t6b.d1", 4'hF, 4'h0, 2'b10, 1'b0, 13);
    asyn_reset = 1'b1;
    pp_valid   = 1'b1;
    step();
    asyn_reset = 1'b0;
    chk("t6b.rst.busy",   8'(busy),    8'd0);
    chk("t6b.rst.zvalid", 8'(z_valid), 8'd0);
    chk("t6b.rst.done",   8'(done),    8'd0);
    chk("t6b.rst.digit",  8'(z_digit), 8'd0);
    step();
    pp_valid = 1'b0;
    chk("t6b.post.zvalid", 8'(z_valid), 8'd0);
    chk("t6b.post.done",   8'(done),    8'd0);
    chk("t6b.post.busy",   8'(busy),    8'd0);

    // clean rerun of test 2
    start_op("t6c.start");
    accept("t6c.d0", 4'hF, 4'h0, 2'b00, 1'b0, 15);
    accept("t6c.d1", 4'hF, 4'h0, 2'b10, 1'b0, 13);
    accept("t6c.d2", 4'hF, 4'h0, 2'b10, 1'b0, 9);
    accept("t6c.d3", 4'hF, 4'h0, 2'b10, 1'b1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
